sram_port_arbiter: RTL and testbench

//   Shares the read/write port (port a) of the dual-port sram between two masters: m0 (CPU data) and m1 (DMA/loader).

---
 rtl/sram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares sram port a between two masters (m0 = CPU data,
//            m1 = DMA/loader) with round-robin arbitration and an optional
//            per-master lock that keeps ownership across multi-word bursts.
//            Read data returns one cycle after the grant, tagged to the
//            master that was granted.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            mX_req/we/lock/addr/wdata   - master X request side (X = 0, 1)
//            mX_gnt                      - access performed this cycle
//            mX_rvalid/rdata             - read response, one cycle after grant
//            sram_addr/wdata/we          - to sram port a
//            sram_rdata                  - from sram port a (one-cycle latency)
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0]      m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [WIDTH-1:0]      m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0]      m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [WIDTH-1:0]      m1_rdata,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [WIDTH-1:0]      sram_wdata,
   output logic                  sram_we,
   input  logic [WIDTH-1:0]      sram_rdata
);

   typedef enum logic [1:0] {
      FREE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    rr_last_q, rr_last_d;   // last granted master
   logic [1:0]              rd_tag_q, rd_tag_d;     // one-hot read pending
   logic [ADDR_WIDTH-1:0]   addr_q;                 // last driven sram address

   logic                    w_gnt0, w_gnt1;

   // Grant decode. Reset overrides everything so no access leaks out while
   // rst is held.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         case (state_q)
            OWN0:    w_gnt0 = m0_req;
            OWN1:    w_gnt1 = m1_req;
            default: begin
               if (m0_req && m1_req) begin
                  // Contest: the master that did not win last time goes.
                  w_gnt0 = rr_last_q;
                  w_gnt1 = ~rr_last_q;
               end else begin
                  w_gnt0 = m0_req;
                  w_gnt1 = m1_req;
               end
            end
         endcase
      end
   end

   // Next-state: a grant decides ownership from the granted master's lock;
   // an idle owner keeps or releases ownership via its own lock.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      rd_tag_d  = {w_gnt1 & ~m1_we, w_gnt0 & ~m0_we};
      if (w_gnt0) begin
         state_d   = m0_lock ? OWN0 : FREE;
         rr_last_d = 1'b0;
      end else if (w_gnt1) begin
         state_d   = m1_lock ? OWN1 : FREE;
         rr_last_d = 1'b1;
      end else begin
         case (state_q)
            OWN0:    if (!m0_lock) state_d = FREE;
            OWN1:    if (!m1_lock) state_d = FREE;
            default: state_d = FREE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FREE;
         rr_last_q <= 1'b1;
         rd_tag_q  <= 2'b00;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         rd_tag_q  <= rd_tag_d;
         addr_q    <= sram_addr;
      end
   end

   // Port a mux. With no grant the address is held so the sram sees a stable
   // bus; write data is zeroed.
   always_comb begin
      sram_addr  = addr_q;
      sram_wdata = '0;
      if (w_gnt0) begin
         sram_addr  = m0_addr;
         sram_wdata = m0_wdata;
      end else if (w_gnt1) begin
         sram_addr  = m1_addr;
         sram_wdata = m1_wdata;
      end
   end

   assign sram_we   = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);
   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = rd_tag_q[0] & ~rst;
   assign m1_rvalid = rd_tag_q[1] & ~rst;
   assign m0_rdata  = sram_rdata;
   assign m1_rdata  = sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Directed self-checking bench for sram_port_arbiter, with a small
//            behavioural write-first sram on port a.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

   localparam int W  = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m0_lock;
   logic [AW-1:0] m0_addr;
   logic [W-1:0]  m0_wdata;
   logic          m0_gnt, m0_rvalid;
   logic [W-1:0]  m0_rdata;
   logic          m1_req, m1_we, m1_lock;
   logic [AW-1:0] m1_addr;
   logic [W-1:0]  m1_wdata;
   logic          m1_gnt, m1_rvalid;
   logic [W-1:0]  m1_rdata;
   logic [AW-1:0] sram_addr;
   logic [W-1:0]  sram_wdata;
   logic          sram_we;
   logic [W-1:0]  sram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
      .sram_rdata(sram_rdata)
   );

   // Behavioural sram port a: registered read, write-first.
   logic [W-1:0] mem [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
   end
   always @(posedge clk) begin
      if (sram_we) begin
         mem[sram_addr] <= sram_wdata;
         sram_rdata     <= sram_wdata;
      end else begin
         sram_rdata     <= mem[sram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
   endtask

   initial begin
      idle_all();
      rst = 1'b1;
      step();
      // Outputs forced low while reset is held, even with a request present.
      m0_req = 1; m0_we = 1; m0_addr = 8'h10;
      #1;
      chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
      chk("rst_sram_we", {31'b0, sram_we}, 32'd0);
      chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
      step();
      rst = 1'b0;
      idle_all();

      // ---- 1: m0 write then read back
      m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 32'hDEADBEEF;
      #1;
      chk("t1_wr_gnt", {31'b0, m0_gnt}, 32'd1);
      chk("t1_wr_m1gnt", {31'b0, m1_gnt}, 32'd0);
      chk("t1_wr_we", {31'b0, sram_we}, 32'd1);
      chk("t1_wr_addr", {24'b0, sram_addr}, 32'h10);
      chk("t1_wr_wdata", sram_wdata, 32'hDEADBEEF);
      step();
      m0_we = 0; m0_wdata = '0;
      #1;
      chk("t1_rd_gnt", {31'b0, m0_gnt}, 32'd1);
      chk("t1_rd_we", {31'b0, sram_we}, 32'd0);
      chk("t1_no_rvalid_after_wr", {31'b0, m0_rvalid}, 32'd0);
      step();
      m0_req = 0;
      #1;
      chk("t1_rvalid", {31'b0, m0_rvalid}, 32'd1);
      chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
      chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
      chk("t1_hold_addr", {24'b0, sram_addr}, 32'h10);
      chk("t1_idle_wdata", sram_wdata, 32'd0);

      // m1 single write so m1 is last granted (m0 wins the next contest)
      m1_req = 1; m1_we = 1; m1_addr = 8'h50; m1_wdata = 32'hCAFE0001;
      #1;
      chk("pre2_m1_gnt", {31'b0, m1_gnt}, 32'd1);
      step();
      idle_all();

      // ---- 2: continuous contest, unlocked reads -> alternate m0,m1,...
      m0_req = 1; m0_addr = 8'h01;
      m1_req = 1; m1_addr = 8'h02;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("t2_m0_gnt_%0d", i), {31'b0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("t2_m1_gnt_%0d", i), {31'b0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk($sformatf("t2_both_%0d", i), {31'b0, m0_gnt & m1_gnt}, 32'd0);
         if (i > 0) begin
            chk($sformatf("t2_m0_rv_%0d", i), {31'b0, m0_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t2_m1_rv_%0d", i), {31'b0, m1_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
         end
         step();
      end
      idle_all();
      #1;
      chk("t2_last_m1_rv", {31'b0, m1_rvalid}, 32'd1);
      chk("t2_last_m1_rd", m1_rdata, 32'hA0000002);

      // m0 preload write 0x5555 @0x05 (also makes m0 last granted)
      m0_req = 1; m0_we = 1; m0_addr = 8'h05; m0_wdata = 32'h00005555;
      #1;
      chk("pre3_m0_gnt", {31'b0, m0_gnt}, 32'd1);
      step();
      idle_all();

      // ---- 3: m1 locked 4-word burst while m0 requests throughout
      m0_req = 1; m0_addr = 8'h40;
      for (int i = 0; i < 4; i++) begin
         m1_req = 1; m1_addr = 8'h20 + 8'(i); m1_lock = (i < 3);
         #1;
         chk($sformatf("t3_m1_gnt_%0d", i), {31'b0, m1_gnt}, 32'd1);
         chk($sformatf("t3_m0_gnt_%0d", i), {31'b0, m0_gnt}, 32'd0);
         chk($sformatf("t3_addr_%0d", i), {24'b0, sram_addr}, 32'h20 + i);
         if (i > 0) begin
            chk($sformatf("t3_rv_%0d", i), {31'b0, m1_rvalid}, 32'd1);
            chk($sformatf("t3_rd_%0d", i), m1_rdata, 32'hA0000020 + i - 1);
         end
         step();
      end
      m1_req = 0; m1_lock = 0;
      #1;
      chk("t3_m0_after", {31'b0, m0_gnt}, 32'd1);
      chk("t3_last_rv", {31'b0, m1_rvalid}, 32'd1);
      chk("t3_last_rd", m1_rdata, 32'hA0000023);
      step();
      m0_req = 0;
      #1;
      chk("t3_m0_rv", {31'b0, m0_rvalid}, 32'd1);
      chk("t3_m0_rd", m0_rdata, 32'hA0000040);

      // ---- 4: m0 read @0x05 then m1 write 0x1234 @0x05 next cycle
      m0_req = 1; m0_addr = 8'h05;
      #1;
      chk("t4_m0_gnt", {31'b0, m0_gnt}, 32'd1);
      step();
      m0_req = 0;
      m1_req = 1; m1_we = 1; m1_addr = 8'h05; m1_wdata = 32'h00001234;
      #1;
      chk("t4_m1_gnt", {31'b0, m1_gnt}, 32'd1);
      chk("t4_m1_we", {31'b0, sram_we}, 32'd1);
      chk("t4_m0_rv", {31'b0, m0_rvalid}, 32'd1);
      chk("t4_m0_old", m0_rdata, 32'h00005555);
      step();
      idle_all();
      // Read right after the write returns the new value
      m0_req = 1; m0_addr = 8'h05;
      #1;
      chk("t4_m1_no_rv", {31'b0, m1_rvalid}, 32'd0);
      step();
      m0_req = 0;
      #1;
      chk("t4_new_rv", {31'b0, m0_rvalid}, 32'd1);
      chk("t4_new_rd", m0_rdata, 32'h00001234);

      // ---- 5: reset the cycle after a locked m1 read grant
      m1_req = 1; m1_lock = 1; m1_addr = 8'h30;
      #1;
      chk("t5_m1_gnt", {31'b0, m1_gnt}, 32'd1);
      step();
      rst = 1'b1;
      idle_all();
      #1;
      chk("t5_rv_in_rst", {31'b0, m1_rvalid}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("t5_rv_after_rst", {31'b0, m1_rvalid}, 32'd0);
      m0_req = 1; m0_addr = 8'h01;
      m1_req = 1; m1_addr = 8'h02;
      #1;
      chk("t5_m0_wins", {31'b0, m0_gnt}, 32'd1);
      chk("t5_m1_loses", {31'b0, m1_gnt}, 32'd0);
      step();
      idle_all();
      step();

      // ---- 6: m0 withdraws its request while m1 holds the lock
      m1_req = 1; m1_lock = 1; m1_addr = 8'h31;
      #1;
      chk("t6_m1_gnt", {31'b0, m1_gnt}, 32'd1);
      step();
      m1_req = 0;
      m0_req = 1; m0_we = 1; m0_addr = 8'h07; m0_wdata = 32'h77777777;
      #1;
      chk("t6_m0_wait", {31'b0, m0_gnt}, 32'd0);
      chk("t6_no_we", {31'b0, sram_we}, 32'd0);
      chk("t6_hold_addr", {24'b0, sram_addr}, 32'h31);
      step();
      m0_req = 0; m0_we = 0; m0_wdata = '0;
      #1;
      chk("t6_m0_gnt_gone", {31'b0, m0_gnt}, 32'd0);
      chk("t6_m0_no_rv", {31'b0, m0_rvalid}, 32'd0);
      chk("t6_mem_untouched", mem[7], 32'hA0000007);
      // Owner releases, then m0 is served
      m1_lock = 0;
      step();
      m0_req = 1; m0_addr = 8'h07;
      #1;
      chk("t6_m0_after_release", {31'b0, m0_gnt}, 32'd1);
      step();
      idle_all();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
